// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared encodings for the nibble-serial add/subtract controller.
package nibble_serial_alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_serial_alu_ctrl_nibble_adder.sv
// Purely combinational 4-bit ripple-carry adder shared by every nibble step.
module nibble_adder (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    output logic [3:0] s4,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s4   = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s4[i]   = a4[i] ^ b4[i] ^ c[i];
            c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
        end
    end

    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// WIDTH-bit add/subtract run one nibble per clock through a single 4-bit adder,
// LSB nibble first, with carry/overflow/zero flags on completion.
module nibble_serial_alu_ctrl
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("nibble_serial_alu_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t            state, state_n;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  a_lat, b_lat, res_fin;
    logic [3:0]        na, nb, ns;
    logic              nc, last;

    // b is stored pre-inverted for subtract; the +1 comes in through the initial carry
    assign na   = a_lat[4*idx +: 4];
    assign nb   = b_lat[4*idx +: 4];
    assign last = (idx == IDXW'(NIBBLES - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    nibble_adder u_add (
        .a4  (na),
        .b4  (nb),
        .cin (carry),
        .s4  (ns),
        .cout(nc)
    );

    // result with the current nibble merged in, so zero sees the complete final value
    always_comb begin
        res_fin              = result;
        res_fin[4*idx +: 4]  = ns;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            a_lat  <= '0;
            b_lat  <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_lat <= a;
                    b_lat <= (op == OP_SUB) ? ~b : b;
                    carry <= op;
                    idx   <= '0;
                end
                RUN: begin
                    result <= res_fin;
                    if (last) begin
                        cout <= nc;
                        ovf  <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) && (ns[3] != a_lat[WIDTH-1]);
                        zero <= (res_fin == '0);
                    end else begin
                        carry <= nc;
                        idx   <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Scoreboarded bench for nibble_serial_alu_ctrl at WIDTH=16.
module tb_nibble_serial_alu_ctrl;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, op;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf, zero;
    logic [15:0] result;

    exp_t sb[$];
    int   checks   = 0;
    int   passes   = 0;
    int   done_cnt = 0;

    nibble_serial_alu_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pops one expectation
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_done: result=%h with empty scoreboard", result);
            end else begin
                e = sb.pop_front();
                if ({result, cout, ovf, zero} !== {e.res, e.c, e.v, e.z})
                    $display("FAIL sb_result: got res=%h c=%b v=%b z=%b, want res=%h c=%b v=%b z=%b",
                             result, cout, ovf, zero, e.res, e.c, e.v, e.z);
                else
                    passes++;
            end
        end
    end

    // Independent full-width reference using integer arithmetic
    function automatic exp_t model(input logic o, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int   sx, sy, sr, ur;
        sx = int'($signed(x));
        sy = int'($signed(y));
        sr = o ? sx - sy : sx + sy;
        ur = o ? int'(x) - int'(y) : int'(x) + int'(y);
        e.res = 16'(ur);
        e.c   = o ? (x >= y) : (ur > 65535);
        e.v   = (sr > 32767) || (sr < -32768);
        e.z   = (16'(ur) == 16'h0);
        return e;
    endfunction

    task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y, input exp_t e);
        int lat, bcnt;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin lat = k; break; end
        end
        checks++;
        if (lat !== 5) $display("FAIL latency: got %0d cycles, want 5", lat);
        else passes++;
        checks++;
        if (bcnt !== 5) $display("FAIL busy_cycles: got %0d, want 5", bcnt);
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result !== e.res || cout !== e.c || ovf !== e.v || zero !== e.z)
            $display("FAIL hold_after_done: busy=%b res=%h c=%b v=%b z=%b, want busy=0 res=%h c=%b v=%b z=%b",
                     busy, result, cout, ovf, zero, e.res, e.c, e.v, e.z);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, cout, ovf, zero} !== '0)
            $display("FAIL reset_state: busy=%b done=%b res=%h c=%b v=%b z=%b, want all 0",
                     busy, done, result, cout, ovf, zero);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_add();
        run_op(1'b0, 16'h1234, 16'h0FFF, '{16'h2233, 1'b0, 1'b0, 1'b0});
        run_op(1'b0, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b0, 1'b1});
        run_op(1'b0, 16'h7FFF, 16'h0001, '{16'h8000, 1'b0, 1'b1, 1'b0});
    endtask

    task automatic test_sub();
        run_op(1'b1, 16'h0005, 16'h0007, '{16'hFFFE, 1'b0, 1'b0, 1'b0});
        run_op(1'b1, 16'h8000, 16'h0001, '{16'h7FFF, 1'b1, 1'b1, 1'b0});
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        op = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, result, cout, ovf, zero} !== '0)
            $display("FAIL reset_mid: busy=%b done=%b res=%h c=%b v=%b z=%b, want all 0",
                     busy, done, result, cout, ovf, zero);
        else passes++;
        repeat (8) @(negedge clk);
        checks++;
        if (done_cnt !== d0) $display("FAIL reset_mid_no_done: got %0d dones, want 0", done_cnt - d0);
        else passes++;
        run_op(1'b0, 16'h00F0, 16'h0010, '{16'h0100, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_busy_reject();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        op = 1'b0; a = 16'h0001; b = 16'h0001; start = 1'b1;
        sb.push_back('{16'h0002, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) $display("FAIL busy_reject_dones: got %0d, want 1", done_cnt - d0);
        else passes++;
        checks++;
        if (result !== 16'h0002) $display("FAIL busy_reject_result: got %h, want 0002", result);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = 0; second = 0;
        @(negedge clk);
        op = 1'b1; a = 16'h0100; b = 16'h0001; start = 1'b1;
        sb.push_back(model(1'b1, 16'h0100, 16'h0001));
        sb.push_back(model(1'b1, 16'h0100, 16'h0001));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (first == 0) first = k;
                else begin second = k; break; end
            end
        end
        start = 1'b0;
        checks++;
        if (second == 0 || second - first !== 6)
            $display("FAIL back_to_back_gap: dones at %0d and %0d, want gap 6", first, second);
        else passes++;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random();
        logic        o;
        logic [15:0] x, y;
        for (int n = 0; n < 8; n++) begin
            o = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            y = 16'($urandom);
            run_op(o, x, y, model(o, x, y));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_reset_mid();
        test_busy_reject();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d results never produced", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
